// File: rtl/ram_initiator.sv
// CPU-side initiator for dev_ram: turns byte/word/long/quad load/store requests
// into RAM ops, splitting quads into two big-endian long accesses.

package pkg_ram;
  localparam int RAM_ADDRW     = 16;
  localparam int RAM_LONG_SIZE = 32;
  typedef enum logic [1:0] {OP_NOP = 2'd0, OP_READ = 2'd1, OP_WRITE = 2'd2} op_t;
  typedef enum logic [1:0] {DT_BYTE = 2'd0, DT_WORD = 2'd1, DT_LONG = 2'd2} data_type_t;
endpackage

module ram_initiator #(
  parameter int RAM_ADDRW  = pkg_ram::RAM_ADDRW,
  parameter int RD_LATENCY = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_write,
  input  logic [1:0]                          req_size,
  input  logic                                req_signed,
  input  logic [RAM_ADDRW-1:0]                req_addr,
  input  logic [63:0]                         req_wdata,
  output logic                                rsp_valid,
  output logic                                rsp_err,
  output logic [63:0]                         rsp_rdata,
  output pkg_ram::op_t                        ram_op,
  output pkg_ram::data_type_t                 ram_data_type,
  output logic [RAM_ADDRW-1:0]                ram_addr,
  output logic [pkg_ram::RAM_LONG_SIZE-1:0]   ram_data_in,
  input  logic [pkg_ram::RAM_LONG_SIZE-1:0]   ram_data_out,
  output logic [2:0]                          dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both 1; rsp_valid is a single-cycle pulse with no back-pressure.

  typedef enum logic [2:0] {S_IDLE, S_ISSUE0, S_ISSUE1, S_WAIT, S_RESP} state_t;

  state_t                  state;
  logic                    q_write;
  logic [1:0]              q_size;
  logic                    q_signed;
  logic [RAM_ADDRW-1:0]    q_addr;
  logic [63:0]             q_wdata;
  logic [1:0]              cnt;
  logic [RD_LATENCY-1:0]   rd_pipe;
  logic [63:0]             acc;
  logic [63:0]             acc_next;
  logic [63:0]             load_ext;
  logic                    misaligned;
  pkg_ram::data_type_t     req_dt;

  assign dbg_state = state;

  always_comb begin
    misaligned = 1'b0;
    req_dt     = pkg_ram::DT_LONG;
    case (req_size)
      2'd0: req_dt = pkg_ram::DT_BYTE;
      2'd1: begin
        req_dt     = pkg_ram::DT_WORD;
        misaligned = req_addr[0];
      end
      2'd2: misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = (req_addr[2:0] != 3'b000);
    endcase
  end

  // Read data is shifted in as it arrives, so a quad ends with {high, low}.
  assign acc_next = rd_pipe[RD_LATENCY-1] ? {acc[31:0], ram_data_out} : acc;

  always_comb begin
    load_ext = acc_next;
    case (q_size)
      2'd0: load_ext = {{56{q_signed & acc_next[7]}},  acc_next[7:0]};
      2'd1: load_ext = {{48{q_signed & acc_next[15]}}, acc_next[15:0]};
      2'd2: load_ext = {{32{q_signed & acc_next[31]}}, acc_next[31:0]};
      default: load_ext = acc_next;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= '0;
      ram_op        <= pkg_ram::OP_NOP;
      ram_data_type <= pkg_ram::DT_LONG;
      ram_addr      <= '0;
      ram_data_in   <= '0;
      q_write       <= 1'b0;
      q_size        <= 2'd0;
      q_signed      <= 1'b0;
      q_addr        <= '0;
      q_wdata       <= '0;
      cnt           <= 2'd0;
      rd_pipe       <= '0;
      acc           <= '0;
    end else begin
      // Tracks which cycles carry valid ram_data_out for reads we issued.
      rd_pipe[0] <= (ram_op == pkg_ram::OP_READ);
      for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
      acc       <= acc_next;
      ram_op    <= pkg_ram::OP_NOP;
      rsp_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            q_write   <= req_write;
            q_size    <= req_size;
            q_signed  <= req_signed;
            q_addr    <= req_addr;
            q_wdata   <= req_wdata;
            if (misaligned) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= S_RESP;
            end else begin
              ram_op        <= req_write ? pkg_ram::OP_WRITE : pkg_ram::OP_READ;
              ram_data_type <= req_dt;
              ram_addr      <= req_addr;
              ram_data_in   <= (req_size == 2'd3) ? req_wdata[63:32] : req_wdata[31:0];
              state         <= S_ISSUE0;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end

        S_ISSUE0: begin
          if (q_size == 2'd3) begin
            ram_op      <= q_write ? pkg_ram::OP_WRITE : pkg_ram::OP_READ;
            ram_addr    <= q_addr + RAM_ADDRW'(4);
            ram_data_in <= q_wdata[31:0];
            state       <= S_ISSUE1;
          end else if (q_write) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            state     <= S_RESP;
          end else begin
            cnt   <= 2'(RD_LATENCY - 1);
            state <= S_WAIT;
          end
        end

        S_ISSUE1: begin
          if (q_write) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            state     <= S_RESP;
          end else begin
            cnt   <= 2'(RD_LATENCY - 1);
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (cnt == 2'd0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= load_ext;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end

        S_RESP: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_initiator.sv
// Directed bench for ram_initiator: two instances (RD_LATENCY 1 and 3), each
// backed by a small big-endian byte RAM model with matching read latency.

module tb_ram_initiator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        sel3 = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [15:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        req_valid1, req_valid3;

  assign req_valid1 = req_valid & ~sel3;
  assign req_valid3 = req_valid & sel3;

  logic                ready1, rsp_valid1, err1, ready3, rsp_valid3, err3;
  logic [63:0]         rdata1, rdata3;
  pkg_ram::op_t        op1, op3;
  pkg_ram::data_type_t dt1, dt3;
  logic [15:0]         addr1, addr3;
  logic [31:0]         din1, din3, dout1, dout3;
  logic [2:0]          dbg1, dbg3;

  ram_initiator #(.RAM_ADDRW(16), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(ready1),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid1),
    .rsp_err(err1), .rsp_rdata(rdata1), .ram_op(op1), .ram_data_type(dt1),
    .ram_addr(addr1), .ram_data_in(din1), .ram_data_out(dout1), .dbg_state(dbg1)
  );

  ram_initiator #(.RAM_ADDRW(16), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(ready3),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid3),
    .rsp_err(err3), .rsp_rdata(rdata3), .ram_op(op3), .ram_data_type(dt3),
    .ram_addr(addr3), .ram_data_in(din3), .ram_data_out(dout3), .dbg_state(dbg3)
  );

  logic                cur_ready, cur_rsp_valid, cur_err;
  logic [63:0]         cur_rdata;
  pkg_ram::op_t        cur_op;
  pkg_ram::data_type_t cur_dt;
  logic [15:0]         cur_addr;
  logic [31:0]         cur_din;

  assign cur_ready     = sel3 ? ready3 : ready1;
  assign cur_rsp_valid = sel3 ? rsp_valid3 : rsp_valid1;
  assign cur_err       = sel3 ? err3 : err1;
  assign cur_rdata     = sel3 ? rdata3 : rdata1;
  assign cur_op        = sel3 ? op3 : op1;
  assign cur_dt        = sel3 ? dt3 : dt1;
  assign cur_addr      = sel3 ? addr3 : addr1;
  assign cur_din       = sel3 ? din3 : din1;

  // RAM models: index 0 serves u_dut1, index 1 serves u_dut3.
  logic [7:0]  mem [2][256];
  logic [31:0] rd_stage [2][3];

  function automatic logic [31:0] mem_rd(int m, pkg_ram::data_type_t dt, logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1; a2 = a + 8'd2; a3 = a + 8'd3;
    case (dt)
      pkg_ram::DT_BYTE: return {24'h0, mem[m][a]};
      pkg_ram::DT_WORD: return {16'h0, mem[m][a], mem[m][a1]};
      default:          return {mem[m][a], mem[m][a1], mem[m][a2], mem[m][a3]};
    endcase
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      pkg_ram::op_t        op;
      pkg_ram::data_type_t dt;
      logic [7:0]          a;
      logic [31:0]         d;
      op = (m == 0) ? op1 : op3;
      dt = (m == 0) ? dt1 : dt3;
      a  = (m == 0) ? addr1[7:0] : addr3[7:0];
      d  = (m == 0) ? din1 : din3;
      if (op == pkg_ram::OP_WRITE) begin
        case (dt)
          pkg_ram::DT_BYTE: mem[m][a] <= d[7:0];
          pkg_ram::DT_WORD: begin
            mem[m][a] <= d[15:8]; mem[m][8'(a + 8'd1)] <= d[7:0];
          end
          default: begin
            mem[m][a] <= d[31:24]; mem[m][8'(a + 8'd1)] <= d[23:16];
            mem[m][8'(a + 8'd2)] <= d[15:8]; mem[m][8'(a + 8'd3)] <= d[7:0];
          end
        endcase
      end
      rd_stage[m][0] <= (op == pkg_ram::OP_READ) ? mem_rd(m, dt, a) : 32'hA5A5A5A5;
      rd_stage[m][1] <= rd_stage[m][0];
      rd_stage[m][2] <= rd_stage[m][1];
    end
  end

  assign dout1 = rd_stage[0][0];
  assign dout3 = rd_stage[1][2];

  int n_vec  = 0;
  int n_miss = 0;

  pkg_ram::op_t        obs_op   [1:4];
  pkg_ram::data_type_t obs_dt   [1:4];
  logic [15:0]         obs_addr [1:4];
  logic [31:0]         obs_din  [1:4];

  // One request; lat is the cycle (1 = cycle after accept) holding rsp_valid.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [15:0] a, input logic [63:0] wd,
                        output int lat, output logic err, output logic [63:0] rd,
                        output logic saw_op);
    int guard;
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    guard = 0;
    while (!cur_ready && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid = 1'b0; req_write = ~w; req_size = ~sz; req_signed = ~sg;
    req_addr = 16'hFFFF; req_wdata = 64'h5555_5555_5555_5555;
    lat = 1; saw_op = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      obs_op[k] = pkg_ram::OP_NOP; obs_dt[k] = pkg_ram::DT_LONG; obs_addr[k] = '0; obs_din[k] = '0;
    end
    while (!cur_rsp_valid && lat < 20) begin
      if (lat <= 4) begin
        obs_op[lat] = cur_op; obs_dt[lat] = cur_dt; obs_addr[lat] = cur_addr; obs_din[lat] = cur_din;
      end
      if (cur_op != pkg_ram::OP_NOP) saw_op = 1'b1;
      @(negedge clk);
      lat++;
    end
    err = cur_err;
    rd  = cur_rdata;
  endtask

  // Holds req_valid high for ncyc cycles and counts accepts and responses.
  task automatic hold_req(input logic w, input logic [1:0] sz, input logic [15:0] a,
                          input logic [63:0] wd, input logic [63:0] exp_rd, input int ncyc,
                          output int acc, output int rsp, output int bad);
    acc = 0; rsp = 0; bad = 0;
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = 1'b0; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      if (cur_ready) acc++;
      if (cur_rsp_valid) begin rsp++; if (cur_rdata !== exp_rd || cur_err !== 1'b0) bad++; end
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (cur_rsp_valid) begin rsp++; if (cur_rdata !== exp_rd) bad++; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (ready1 !== 1'b0) begin n_miss++; $display("FAIL rst_ready got %b want 0", ready1); end
    n_vec++; if (rsp_valid1 !== 1'b0) begin n_miss++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid1); end
    n_vec++; if (err1 !== 1'b0) begin n_miss++; $display("FAIL rst_err got %b want 0", err1); end
    n_vec++; if (rdata1 !== 64'h0) begin n_miss++; $display("FAIL rst_rdata got %h want 0", rdata1); end
    n_vec++; if (op1 !== pkg_ram::OP_NOP) begin n_miss++; $display("FAIL rst_op got %0d want NOP", op1); end
    n_vec++; if (dt1 !== pkg_ram::DT_LONG) begin n_miss++; $display("FAIL rst_dt got %0d want LONG", dt1); end
    n_vec++; if (addr1 !== 16'h0) begin n_miss++; $display("FAIL rst_addr got %h want 0", addr1); end
    n_vec++; if (din1 !== 32'h0) begin n_miss++; $display("FAIL rst_din got %h want 0", din1); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (ready1 !== 1'b1) begin n_miss++; $display("FAIL rst_ready_after got %b want 1", ready1); end
  endtask

  task automatic test_long();
    int lat; logic err; logic [63:0] rd; logic saw;
    do_req(1'b1, 2'd2, 1'b0, 16'h0010, 64'h1111_2222_DEAD_BEEF, lat, err, rd, saw);
    n_vec++; if (lat !== 2) begin n_miss++; $display("FAIL st_long_lat got %0d want 2", lat); end
    n_vec++; if (rd !== 64'h0 || err !== 1'b0) begin n_miss++; $display("FAIL st_long_rsp got %h/%b want 0/0", rd, err); end
    n_vec++; if (obs_op[1] !== pkg_ram::OP_WRITE || obs_dt[1] !== pkg_ram::DT_LONG || obs_addr[1] !== 16'h0010 || obs_din[1] !== 32'hDEADBEEF)
      begin n_miss++; $display("FAIL st_long_op got %0d/%0d/%h/%h want WRITE/LONG/0010/deadbeef", obs_op[1], obs_dt[1], obs_addr[1], obs_din[1]); end
    do_req(1'b0, 2'd2, 1'b0, 16'h0010, 64'h0, lat, err, rd, saw);
    n_vec++; if (lat !== 3) begin n_miss++; $display("FAIL ld_long_lat got %0d want 3", lat); end
    n_vec++; if (rd !== 64'h0000_0000_DEAD_BEEF) begin n_miss++; $display("FAIL ld_long_data got %h want 00000000deadbeef", rd); end
    n_vec++; if (obs_op[1] !== pkg_ram::OP_READ || obs_addr[1] !== 16'h0010) begin n_miss++; $display("FAIL ld_long_op got %0d/%h want READ/0010", obs_op[1], obs_addr[1]); end
  endtask

  task automatic test_quad();
    int lat; logic err; logic [63:0] rd; logic saw;
    do_req(1'b1, 2'd3, 1'b0, 16'h0020, 64'h0123_4567_89AB_CDEF, lat, err, rd, saw);
    n_vec++; if (lat !== 3) begin n_miss++; $display("FAIL st_quad_lat got %0d want 3", lat); end
    n_vec++; if (obs_op[1] !== pkg_ram::OP_WRITE || obs_dt[1] !== pkg_ram::DT_LONG || obs_addr[1] !== 16'h0020 || obs_din[1] !== 32'h01234567)
      begin n_miss++; $display("FAIL st_quad_hi got %0d/%0d/%h/%h want WRITE/LONG/0020/01234567", obs_op[1], obs_dt[1], obs_addr[1], obs_din[1]); end
    n_vec++; if (obs_op[2] !== pkg_ram::OP_WRITE || obs_dt[2] !== pkg_ram::DT_LONG || obs_addr[2] !== 16'h0024 || obs_din[2] !== 32'h89ABCDEF)
      begin n_miss++; $display("FAIL st_quad_lo got %0d/%0d/%h/%h want WRITE/LONG/0024/89abcdef", obs_op[2], obs_dt[2], obs_addr[2], obs_din[2]); end
    do_req(1'b0, 2'd3, 1'b1, 16'h0020, 64'h0, lat, err, rd, saw);
    n_vec++; if (lat !== 4) begin n_miss++; $display("FAIL ld_quad_lat got %0d want 4", lat); end
    n_vec++; if (rd !== 64'h0123_4567_89AB_CDEF) begin n_miss++; $display("FAIL ld_quad_data got %h want 0123456789abcdef", rd); end
    n_vec++; if (obs_op[1] !== pkg_ram::OP_READ || obs_op[2] !== pkg_ram::OP_READ || obs_addr[2] !== 16'h0024)
      begin n_miss++; $display("FAIL ld_quad_ops got %0d/%0d/%h want READ/READ/0024", obs_op[1], obs_op[2], obs_addr[2]); end
  endtask

  task automatic test_ext();
    int lat; logic err; logic [63:0] rd; logic saw;
    do_req(1'b1, 2'd0, 1'b0, 16'h0031, 64'hAAAA_AAAA_AAAA_AA80, lat, err, rd, saw);
    n_vec++; if (obs_dt[1] !== pkg_ram::DT_BYTE || obs_addr[1] !== 16'h0031) begin n_miss++; $display("FAIL st_byte_op got %0d/%h want BYTE/0031", obs_dt[1], obs_addr[1]); end
    do_req(1'b0, 2'd0, 1'b1, 16'h0031, 64'h0, lat, err, rd, saw);
    n_vec++; if (rd !== 64'hFFFF_FFFF_FFFF_FF80) begin n_miss++; $display("FAIL ld_byte_s got %h want ffffffffffffff80", rd); end
    do_req(1'b0, 2'd0, 1'b0, 16'h0031, 64'h0, lat, err, rd, saw);
    n_vec++; if (rd !== 64'h0000_0000_0000_0080) begin n_miss++; $display("FAIL ld_byte_u got %h want 0000000000000080", rd); end
    do_req(1'b1, 2'd1, 1'b0, 16'h0040, 64'h0000_0000_0000_8001, lat, err, rd, saw);
    do_req(1'b0, 2'd1, 1'b1, 16'h0040, 64'h0, lat, err, rd, saw);
    n_vec++; if (rd !== 64'hFFFF_FFFF_FFFF_8001) begin n_miss++; $display("FAIL ld_word_s got %h want ffffffffffff8001", rd); end
    n_vec++; if (obs_dt[1] !== pkg_ram::DT_WORD) begin n_miss++; $display("FAIL ld_word_dt got %0d want WORD", obs_dt[1]); end
    do_req(1'b0, 2'd2, 1'b1, 16'h0010, 64'h0, lat, err, rd, saw);
    n_vec++; if (rd !== 64'hFFFF_FFFF_DEAD_BEEF) begin n_miss++; $display("FAIL ld_long_s got %h want ffffffffdeadbeef", rd); end
  endtask

  task automatic test_misaligned();
    int lat; logic err; logic [63:0] rd; logic saw;
    logic [1:0]  szs [3];
    logic [15:0] ads [3];
    szs[0] = 2'd1; ads[0] = 16'h0003;
    szs[1] = 2'd2; ads[1] = 16'h0006;
    szs[2] = 2'd3; ads[2] = 16'h000C;
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, szs[i], 1'b0, ads[i], 64'h0, lat, err, rd, saw);
      n_vec++; if (lat !== 1) begin n_miss++; $display("FAIL mis%0d_lat got %0d want 1", i, lat); end
      n_vec++; if (err !== 1'b1) begin n_miss++; $display("FAIL mis%0d_err got %b want 1", i, err); end
      n_vec++; if (rd !== 64'h0) begin n_miss++; $display("FAIL mis%0d_rdata got %h want 0", i, rd); end
      @(negedge clk);
      n_vec++; if (saw !== 1'b0 || cur_op !== pkg_ram::OP_NOP) begin n_miss++; $display("FAIL mis%0d_op got saw=%b op=%0d want 0/NOP", i, saw, cur_op); end
    end
    do_req(1'b0, 2'd2, 1'b0, 16'h0010, 64'h0, lat, err, rd, saw);
    n_vec++; if (err !== 1'b0 || rd !== 64'h0000_0000_DEAD_BEEF) begin n_miss++; $display("FAIL after_mis got %b/%h want 0/00000000deadbeef", err, rd); end
  endtask

  task automatic test_reset_mid();
    int guard, nrsp, lat; logic err; logic [63:0] rd; logic saw;
    @(negedge clk);
    req_write = 1'b0; req_size = 2'd3; req_signed = 1'b0; req_addr = 16'h0020; req_valid = 1'b1;
    guard = 0;
    while (!cur_ready && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid = 1'b0;
    n_vec++; if (cur_op !== pkg_ram::OP_READ) begin n_miss++; $display("FAIL rmid_first_read got %0d want READ", cur_op); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (cur_op !== pkg_ram::OP_NOP || cur_rsp_valid !== 1'b0) begin n_miss++; $display("FAIL rmid_nop got %0d/%b want NOP/0", cur_op, cur_rsp_valid); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (cur_ready !== 1'b1) begin n_miss++; $display("FAIL rmid_ready got %b want 1", cur_ready); end
    nrsp = 0;
    for (int i = 0; i < 5; i++) begin if (cur_rsp_valid) nrsp++; @(negedge clk); end
    n_vec++; if (nrsp !== 0) begin n_miss++; $display("FAIL rmid_no_rsp got %0d want 0", nrsp); end
    do_req(1'b0, 2'd2, 1'b0, 16'h0010, 64'h0, lat, err, rd, saw);
    n_vec++; if (rd !== 64'h0000_0000_DEAD_BEEF || lat !== 3) begin n_miss++; $display("FAIL rmid_reload got %h/%0d want 00000000deadbeef/3", rd, lat); end
  endtask

  task automatic test_back_to_back();
    int acc, rsp, bad;
    hold_req(1'b1, 2'd2, 16'h0050, 64'h0000_0000_CAFE_F00D, 64'h0, 12, acc, rsp, bad);
    n_vec++; if (acc !== 4 || rsp !== 4 || bad !== 0) begin n_miss++; $display("FAIL b2b_store got acc=%0d rsp=%0d bad=%0d want 4/4/0", acc, rsp, bad); end
  endtask

  task automatic test_lat3();
    int lat, acc, rsp, bad; logic err; logic [63:0] rd; logic saw;
    sel3 = 1'b1;
    do_req(1'b1, 2'd3, 1'b0, 16'h0020, 64'h0123_4567_89AB_CDEF, lat, err, rd, saw);
    n_vec++; if (lat !== 3) begin n_miss++; $display("FAIL l3_st_quad_lat got %0d want 3", lat); end
    do_req(1'b0, 2'd3, 1'b0, 16'h0020, 64'h0, lat, err, rd, saw);
    n_vec++; if (lat !== 6) begin n_miss++; $display("FAIL l3_ld_quad_lat got %0d want 6", lat); end
    n_vec++; if (rd !== 64'h0123_4567_89AB_CDEF) begin n_miss++; $display("FAIL l3_ld_quad_data got %h want 0123456789abcdef", rd); end
    hold_req(1'b0, 2'd2, 16'h0020, 64'h0, 64'h0000_0000_0123_4567, 36, acc, rsp, bad);
    n_vec++; if (acc !== 6 || rsp !== 6 || bad !== 0) begin n_miss++; $display("FAIL l3_hold got acc=%0d rsp=%0d bad=%0d want 6/6/0", acc, rsp, bad); end
    sel3 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_long();
    test_quad();
    test_ext();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    test_lat3();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
